if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage and the producer side of the IF/ID pipeline register: drives pc_if, pc_plus_4_if and instr_if, and obeys that register's stall/flush contract.
- Owns the PC, issues requests to instruction memory over a request/grant and in-order response handshake, and buffers returned instructions in a small FIFO.
- On a redirect (taken branch/jump/flush) it discards stale in-flight responses and refetches from the new target.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
DEPTH, 2, fetch buffer entries; also max (buffered + outstanding) requests
NOP, 32'h0000_0013, instruction presented when buffer empty (addi x0,x0,0)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-high (asserted when rst_n=1)
stall  in  1  IF/ID holding; head entry must not be consumed
redirect  in  1  discard all fetch state, restart at redirect_pc
redirect_pc  in  32  new fetch target; bits[1:0] forced to 0
imem_req  out  1  request valid
imem_addr  out  32  word-aligned request address (= pc register)
imem_gnt  in  1  request accepted this cycle when imem_req=1
imem_rvalid  in  1  response valid; responses return in request order
imem_rdata  in  32  response instruction
pc_if  out  32  PC of head entry
pc_plus_4_if  out  32  pc_if + 4 (mod 2^32)
instr_if  out  32  head instruction, or NOP when empty
instr_valid_if  out  1  head entry present

Behaviour:
- Reset (rst_n=1, asynchronous): pc <= RESET_PC; buffer count=0; outstanding=0; kill=0. Outputs while in reset: imem_req=0, pc_if=0, pc_plus_4_if=0, instr_if=NOP, instr_valid_if=0. Reset asserted mid-transaction drops everything; responses arriving after reset deasserts while kill=0 are accepted, so the memory side is reset concurrently.
- pop = !stall && count>0 (combinational). Head is removed at the clock edge when pop=1.
- imem_req = !redirect && (count + outstanding - pop) < DEPTH. imem_addr = pc.
- Grant: imem_req && imem_gnt -> pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0); outstanding++. The PC of each outstanding request is recorded in an in-order tag queue of DEPTH entries.
- Response: imem_rvalid with kill>0 -> dropped, kill--. Otherwise push {tag pc, imem_rdata} into the buffer and outstanding--.
- Simultaneous push and pop on a non-empty buffer is legal and leaves count unchanged. Simultaneous grant and response updates outstanding by the net amount.
- Latency: grant in cycle N, earliest rvalid N+1, head visible on the outputs at N+2. Steady-state throughput is 1 instr/cycle at DEPTH=2 with 1-cycle memory.
- Outputs are combinational from the buffer head: pc_if=head.pc, pc_plus_4_if=head.pc+4, instr_if=head.instr, instr_valid_if=1. When empty: 0, 0, NOP, 0.
- Redirect, effective at the next edge:
  - pc <= {redirect_pc[31:2],2'b00}.
  - Buffer and tag queue cleared.
  - kill <= kill + outstanding - (imem_rvalid?1:0); outstanding <= 0.
  - Any response in the redirect cycle itself is dropped.
  - imem_req is forced to 0 in the redirect cycle, so the first new request issues the cycle after.
- Priority: redirect over stall; redirect over grant/response bookkeeping.
- Overflow: imem_rvalid with outstanding=0 and kill=0 is a protocol error. Assertion only; the response is ignored.
- Invariant: count + outstanding <= DEPTH; kill <= DEPTH.

Test Plan:
- Reset then release; imem_gnt=1, memory latency 1, rdata=addr^32'hA5A5_0000, stall=0 -> requests at 0x0, 0x4, 0x8, ... every cycle from cycle 1. pc_if 0x0/instr 32'hA5A5_0000 valid at cycle 3, incrementing by 4 each cycle. During reset: instr_if=0x13, pc_if=0.
- Streaming, then stall high 3 cycles -> pc_if/instr_if frozen. imem_req drops once count+outstanding=DEPTH. After release, no instruction is skipped or duplicated.
- imem_gnt held 0 for 4 cycles -> imem_req stays 1, imem_addr constant, pc does not advance. Buffer drains to empty: instr_if=0x13, instr_valid_if=0.
- Two requests outstanding, memory latency 3, redirect with redirect_pc=0x0000_0103 -> next imem_addr=0x100. Both late responses dropped (kill 2->0). First valid head is pc_if=0x100.
- redirect and stall high in the same cycle as imem_rvalid -> response dropped, buffer empty next cycle, refetch from target.
- redirect_pc=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000. pc_plus_4_if of the first = 0x0000_0000.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order requests to instruction
// memory, and buffers returned words as the producer side of the IF/ID register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_if,
   output logic [31:0] pc_plus_4_if,
   output logic [31:0] instr_if,
   output logic        instr_valid_if
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // Handshake: a request transfers on a cycle with imem_req && imem_gnt; the
   // memory answers each transferred request with exactly one imem_rvalid pulse, in order.

   logic [31:0]   r_pc;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_out;
   logic [CW-1:0] r_kill;
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_tag_rd;
   logic [PW-1:0] r_tag_wr;
   logic [31:0]   r_buf_pc  [DEPTH];
   logic [31:0]   r_buf_ins [DEPTH];
   logic [31:0]   r_tag     [DEPTH];

   logic          w_empty;
   logic          w_pop;
   logic [CW:0]   w_occ;
   logic          w_grant;
   logic          w_drop;
   logic          w_accept;
   logic          w_rvalid_live;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_empty       = (r_count == '0);
   assign w_pop         = !stall && !w_empty;
   assign w_occ         = {1'b0, r_count} + {1'b0, r_out} - (CW+1)'(w_pop);
   assign imem_req      = !rst_n && !redirect && (w_occ < (CW+1)'(DEPTH));
   assign imem_addr     = r_pc;
   assign w_grant       = imem_req && imem_gnt;
   assign w_drop        = imem_rvalid && (r_kill != '0);
   assign w_accept      = imem_rvalid && (r_kill == '0) && (r_out != '0);
   // A response with nothing outstanding and nothing to kill must not underflow kill.
   assign w_rvalid_live = imem_rvalid && ((r_kill != '0) || (r_out != '0));

   assign instr_valid_if = !w_empty;
   assign pc_if          = w_empty ? 32'h0 : r_buf_pc[r_rd];
   assign pc_plus_4_if   = w_empty ? 32'h0 : r_buf_pc[r_rd] + 32'd4;
   assign instr_if       = w_empty ? NOP   : r_buf_ins[r_rd];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_pc     <= RESET_PC;
         r_count  <= '0;
         r_out    <= '0;
         r_kill   <= '0;
         r_rd     <= '0;
         r_wr     <= '0;
         r_tag_rd <= '0;
         r_tag_wr <= '0;
      end else if (redirect) begin
         r_pc     <= {redirect_pc[31:2], 2'b00};
         r_count  <= '0;
         r_out    <= '0;
         r_kill   <= r_kill + r_out - CW'(w_rvalid_live);
         r_rd     <= '0;
         r_wr     <= '0;
         r_tag_rd <= '0;
         r_tag_wr <= '0;
      end else begin
         if (w_grant) begin
            r_pc            <= r_pc + 32'd4;
            r_tag[r_tag_wr] <= r_pc;
            r_tag_wr        <= f_inc(r_tag_wr);
         end
         if (w_drop) begin
            r_kill <= r_kill - CW'(1);
         end
         if (w_accept) begin
            r_buf_pc[r_wr]  <= r_tag[r_tag_rd];
            r_buf_ins[r_wr] <= imem_rdata;
            r_wr            <= f_inc(r_wr);
            r_tag_rd        <= f_inc(r_tag_rd);
         end
         if (w_pop) begin
            r_rd <= f_inc(r_rd);
         end
         r_count <= r_count + CW'(w_accept) - CW'(w_pop);
         r_out   <= r_out + CW'(w_grant) - CW'(w_accept);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         assert (!(imem_rvalid && (r_out == '0) && (r_kill == '0)));
         assert (({1'b0, r_count} + {1'b0, r_out}) <= (CW+1)'(DEPTH));
         assert (r_kill <= CW'(DEPTH));
      end
   end

endmodule
